cdc_hs_rx: RTL and testbench



---
 rtl/cdc_hs_rx_pkg.sv | 14 +
 rtl/cdc_hs_rx_if.sv | 42 ++++
 rtl/cdc_hs_rx_sync.sv | 21 ++
 rtl/cdc_hs_rx.sv | 110 +++++++++++
 tb/tb_cdc_hs_rx.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdc_hs_rx_pkg.sv
// Shared types for the handshake receiver: FSM state encoding and the
// minimum legal depth of the req synchronizer.
package cdc_pkg;

  typedef enum logic [1:0] {
    RST_WAIT,
    IDLE,
    DELIVER,
    ACK
  } state_t;

  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/cdc_hs_rx_if.sv
// Handshake bundle between the source domain, the receiver and the consumer.
// The slave modport is the receiver's view; master is the environment's view.
// Optional parity signals exist only when CDC_HS_RX_PARITY_EN is defined.
interface cdc_hs_rx_if #(
  parameter int DATA_W = 8
);

  logic              async_req_i;
  logic [DATA_W-1:0] async_data_i;
  logic              ack_o;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              ready_i;
  logic              proto_err_o;
`ifdef CDC_HS_RX_PARITY_EN
  logic              async_par_i;
  logic              par_err_o;
`endif

`ifdef CDC_HS_RX_PARITY_EN
  modport slave (
    input  async_req_i, async_data_i, async_par_i, ready_i,
    output ack_o, data_o, valid_o, proto_err_o, par_err_o
  );

  modport master (
    output async_req_i, async_data_i, async_par_i, ready_i,
    input  ack_o, data_o, valid_o, proto_err_o, par_err_o
  );
`else
  modport slave (
    input  async_req_i, async_data_i, ready_i,
    output ack_o, data_o, valid_o, proto_err_o
  );

  modport master (
    output async_req_i, async_data_i, ready_i,
    input  ack_o, data_o, valid_o, proto_err_o
  );
`endif

endinterface

// File: rtl/cdc_hs_rx_sync.sv
// N-flop single-bit synchronizer, asynchronously cleared to 0.
module cdc_sync_bit #(
  parameter int N = 2
) (
  input  logic clkB,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] chain;

  // Shift the asynchronous level through the flop chain.
  always_ff @(posedge clkB or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[N-2:0], d};
  end

  assign q = chain[N-1];

endmodule

// File: rtl/cdc_hs_rx.sv
// Destination-side responder of a 4-phase req/ack handshake. The req level is
// synchronized; the data bus is sampled raw, only in the capture cycle, when
// the source guarantees it is stable. Optional parity check: define
// CDC_HS_RX_PARITY_EN.
module cdc_hs_rx
  import cdc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic         clkB,
  input logic         rst_n,
  cdc_hs_rx_if.slave  bus
);

  generate
    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : gBadStages
      $error("cdc_hs_rx: SYNC_STAGES must be at least 2");
    end
  endgenerate

  localparam int                CNT_W     = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(SYNC_STAGES);

  state_t            state;
  logic [CNT_W-1:0]  waitCnt;
  logic              reqSync;
  logic              ackReg;
  logic              validReg;
  logic [DATA_W-1:0] dataReg;
  logic              protoErrReg;
  logic              errSeen;     // a withdrawal was already flagged for this word
`ifdef CDC_HS_RX_PARITY_EN
  logic              parErrReg;
`endif

  cdc_sync_bit #(.N(SYNC_STAGES)) reqSyncInst (
    .clkB  (clkB),
    .rst_n (rst_n),
    .d     (bus.async_req_i),
    .q     (reqSync)
  );

  // Handshake FSM; every output is a flop so nothing combinational reaches a port.
  always_ff @(posedge clkB or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RST_WAIT;
      waitCnt     <= '0;
      ackReg      <= 1'b0;
      validReg    <= 1'b0;
      dataReg     <= '0;
      protoErrReg <= 1'b0;
      errSeen     <= 1'b0;
`ifdef CDC_HS_RX_PARITY_EN
      parErrReg   <= 1'b0;
`endif
    end else begin
      protoErrReg <= 1'b0;
      case (state)
        // Let the chain flush, then refuse any req still high from before reset.
        RST_WAIT: begin
          if (waitCnt != WAIT_LAST) waitCnt <= waitCnt + 1'b1;
          else if (!reqSync)        state   <= IDLE;
        end
        IDLE: begin
          if (reqSync) begin
            dataReg  <= bus.async_data_i;
            validReg <= 1'b1;
            errSeen  <= 1'b0;
`ifdef CDC_HS_RX_PARITY_EN
            parErrReg <= (^bus.async_data_i) ^ bus.async_par_i;
`endif
            state    <= DELIVER;
          end
        end
        DELIVER: begin
          // Source dropped req before seeing ack: flag it once, keep delivering.
          if (!reqSync && !errSeen) begin
            protoErrReg <= 1'b1;
            errSeen     <= 1'b1;
          end
          if (bus.ready_i) begin
            validReg <= 1'b0;
            ackReg   <= 1'b1;
`ifdef CDC_HS_RX_PARITY_EN
            parErrReg <= 1'b0;
`endif
            state    <= ACK;
          end
        end
        ACK: begin
          if (!reqSync) begin
            ackReg <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= RST_WAIT;
      endcase
    end
  end

  assign bus.ack_o       = ackReg;
  assign bus.valid_o     = validReg;
  assign bus.data_o      = dataReg;
  assign bus.proto_err_o = protoErrReg;
`ifdef CDC_HS_RX_PARITY_EN
  assign bus.par_err_o   = parErrReg;
`endif

endmodule

// File: tb/tb_cdc_hs_rx.sv
// Self-checking bench for cdc_hs_rx: directed scenarios plus randomized
// transfers from a separate source clock, scored against a FIFO of sent words.
`timescale 1ns/1ps
module tb_cdc_hs_rx;

  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;

  logic    clkB = 1'b0;
  logic    clkA = 1'b0;
  logic    rst_n = 1'b0;
  realtime clkAHalf = 15.0;

  cdc_hs_rx_if #(.DATA_W(DATA_W)) bus();

  cdc_hs_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clkB  (clkB),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clkB = ~clkB;
  initial begin
    #3;
    forever #(clkAHalf) clkA = ~clkA;
  end

  int checks = 0;
  int errors = 0;

  // Consumer and monitor: ready_i mode 0 = low, 1 = high, 2 = random.
  int         rdyMode = 1;
  logic [7:0] accQ[$];
  int         validRises = 0;
  int         protoCnt = 0;
  int         overlapCnt = 0;
  logic       prevValid = 1'b0;

  always @(negedge clkB) begin
    logic nr;
    if (bus.valid_o === 1'b1 && bus.ack_o === 1'b1) overlapCnt++;
    if (bus.proto_err_o === 1'b1) protoCnt++;
    if (bus.valid_o === 1'b1 && prevValid !== 1'b1) validRises++;
    prevValid = bus.valid_o;
    nr = (rdyMode == 2) ? 1'($urandom_range(0, 1)) : (rdyMode == 1);
    bus.ready_i = nr;
    // valid_o and ready_i both hold until the next posedge, so the word is taken there.
    if (bus.valid_o === 1'b1 && nr && rst_n) accQ.push_back(bus.data_o);
  end

  task automatic clearMon();
    accQ.delete();
    validRises = 0;
    protoCnt   = 0;
    overlapCnt = 0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    bus.async_req_i  = 1'b0;
    bus.async_data_i = '0;
`ifdef CDC_HS_RX_PARITY_EN
    bus.async_par_i  = 1'b0;
`endif
    repeat (3) @(negedge clkB);
    rst_n = 1'b1;
    repeat (5) @(negedge clkB);
  endtask

  // Source-domain initiator on clkA: data first, then req, hold until ack, release.
  task automatic srcSend(input logic [7:0] d, output bit ok);
    int t;
    ok = 1'b1;
    @(posedge clkA);
    bus.async_data_i = d;
`ifdef CDC_HS_RX_PARITY_EN
    bus.async_par_i = ^d;
`endif
    @(posedge clkA);
    bus.async_req_i = 1'b1;
    t = 0;
    while (bus.ack_o !== 1'b1 && t < 5000) begin @(posedge clkA); t++; end
    if (bus.ack_o !== 1'b1) ok = 1'b0;
    bus.async_req_i = 1'b0;
    t = 0;
    while (bus.ack_o !== 1'b0 && t < 5000) begin @(posedge clkA); t++; end
    if (bus.ack_o !== 1'b0) ok = 1'b0;
  endtask

  task automatic test_reset();
    int t;
    rst_n = 1'b0;
    bus.async_req_i  = 1'b0;
    bus.async_data_i = '0;
`ifdef CDC_HS_RX_PARITY_EN
    bus.async_par_i  = 1'b0;
`endif
    #22;
    checks++;
    if ({bus.ack_o, bus.valid_o, bus.proto_err_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl ack/valid/perr=%b required 000", {bus.ack_o, bus.valid_o, bus.proto_err_o});
    end
    checks++;
    if (bus.data_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_data data_o=%h required 00", bus.data_o);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clkB);
    // Reset while a word is being presented must clear outputs without a clock edge.
    rdyMode = 0;
    bus.async_data_i = 8'h42;
    bus.async_req_i  = 1'b1;
    t = 0;
    while (bus.valid_o !== 1'b1 && t < 20) begin @(negedge clkB); t++; end
    checks++;
    if (bus.valid_o !== 1'b1) begin
      errors++;
      $display("FAIL midreset_setup valid_o=%b required 1", bus.valid_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.valid_o, bus.ack_o, bus.data_o} !== 10'h000) begin
      errors++;
      $display("FAIL midreset_async valid=%b ack=%b data=%h required 0 0 00", bus.valid_o, bus.ack_o, bus.data_o);
    end
    rdyMode = 1;
    doReset();
  endtask

  task automatic test_latency();
    int n;
    doReset();
    rdyMode = 1;
    clearMon();
    @(negedge clkB);
    bus.async_data_i = 8'hA5;
    bus.async_req_i  = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clkB); #1;
      checks++;
      if (bus.valid_o !== (e == 3)) begin
        errors++;
        $display("FAIL latency_edge%0d valid_o=%b required %b", e, bus.valid_o, (e == 3));
      end
    end
    checks++;
    if (bus.data_o !== 8'hA5) begin
      errors++;
      $display("FAIL latency_data data_o=%h required a5", bus.data_o);
    end
    @(posedge clkB); #1;
    checks++;
    if ({bus.valid_o, bus.ack_o} !== 2'b01) begin
      errors++;
      $display("FAIL latency_ack valid/ack=%b required 01", {bus.valid_o, bus.ack_o});
    end
    @(negedge clkB);
    bus.async_req_i = 1'b0;
    n = 0;
    do begin @(posedge clkB); #1; n++; end while (bus.ack_o !== 1'b0 && n < 10);
    checks++;
    if (n < 2 || n > 3) begin
      errors++;
      $display("FAIL ack_release edges=%0d required 2..3", n);
    end
    checks++;
    if (accQ.size() != 1 || accQ[0] !== 8'hA5) begin
      errors++;
      $display("FAIL latency_accept count=%0d required 1 of a5", accQ.size());
    end
  endtask

  task automatic test_ready_hold();
    int t;
    rdyMode = 0;
    clearMon();
    @(negedge clkB);
    bus.async_data_i = 8'h3C;
    bus.async_req_i  = 1'b1;
    t = 0;
    while (bus.valid_o !== 1'b1 && t < 20) begin @(negedge clkB); t++; end
    checks++;
    if (bus.valid_o !== 1'b1) begin
      errors++;
      $display("FAIL hold_valid valid_o=%b required 1", bus.valid_o);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clkB);
      checks++;
      if (bus.data_o !== 8'h3C || bus.ack_o !== 1'b0 || bus.valid_o !== 1'b1) begin
        errors++;
        $display("FAIL hold_cycle%0d data=%h ack=%b valid=%b required 3c 0 1", i, bus.data_o, bus.ack_o, bus.valid_o);
      end
    end
    checks++;
    if (validRises != 1) begin
      errors++;
      $display("FAIL hold_captures rises=%0d required 1", validRises);
    end
    @(posedge clkB);
    rdyMode = 1;
    @(negedge clkB);
    @(negedge clkB);
    checks++;
    if ({bus.ack_o, bus.valid_o} !== 2'b10) begin
      errors++;
      $display("FAIL hold_release ack/valid=%b required 10", {bus.ack_o, bus.valid_o});
    end
    bus.async_req_i = 1'b0;
    t = 0;
    while (bus.ack_o !== 1'b0 && t < 20) begin @(negedge clkB); t++; end
    checks++;
    if (accQ.size() != 1 || accQ[0] !== 8'h3C || bus.ack_o !== 1'b0) begin
      errors++;
      $display("FAIL hold_accept count=%0d ack=%b required 1 of 3c, ack 0", accQ.size(), bus.ack_o);
    end
  endtask

  task automatic test_back_to_back(input realtime half, input string tag);
    logic [7:0] expQ[$];
    logic [7:0] d;
    bit ok;
    clkAHalf = half;
    rdyMode = 2;
    clearMon();
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      expQ.push_back(d);
      srcSend(d, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL b2b_%s_handshake%0d timed out waiting for ack", tag, i);
      end
    end
    repeat (5) @(negedge clkB);
    rdyMode = 1;
    checks++;
    if (accQ.size() != expQ.size()) begin
      errors++;
      $display("FAIL b2b_%s_count got=%0d required %0d", tag, accQ.size(), expQ.size());
    end
    for (int i = 0; i < expQ.size() && i < accQ.size(); i++) begin
      checks++;
      if (accQ[i] !== expQ[i]) begin
        errors++;
        $display("FAIL b2b_%s_word%0d got=%h required %h", tag, i, accQ[i], expQ[i]);
      end
    end
    checks++;
    if (overlapCnt != 0 || protoCnt != 0) begin
      errors++;
      $display("FAIL b2b_%s_clean overlap=%0d perr=%0d required 0 0", tag, overlapCnt, protoCnt);
    end
  endtask

  task automatic test_stale_req();
    int t;
    rst_n = 1'b0;
    bus.async_data_i = 8'h77;
    bus.async_req_i  = 1'b1;
    repeat (3) @(negedge clkB);
    rst_n = 1'b1;
    rdyMode = 1;
    clearMon();
    repeat (20) @(negedge clkB);
    checks++;
    if (validRises != 0) begin
      errors++;
      $display("FAIL stale_capture rises=%0d required 0", validRises);
    end
    bus.async_req_i = 1'b0;
    repeat (5) @(negedge clkB);
    bus.async_data_i = 8'h99;
    bus.async_req_i  = 1'b1;
    t = 0;
    while (bus.ack_o !== 1'b1 && t < 20) begin @(negedge clkB); t++; end
    bus.async_req_i = 1'b0;
    t = 0;
    while (bus.ack_o !== 1'b0 && t < 20) begin @(negedge clkB); t++; end
    checks++;
    if (accQ.size() != 1 || accQ[0] !== 8'h99) begin
      errors++;
      $display("FAIL stale_fresh count=%0d first=%h required 1 of 99", accQ.size(), (accQ.size() > 0) ? accQ[0] : 8'h00);
    end
  endtask

  task automatic test_proto_err();
    int t;
    rdyMode = 0;
    clearMon();
    @(negedge clkB);
    bus.async_data_i = 8'h5A;
    bus.async_req_i  = 1'b1;
    t = 0;
    while (bus.valid_o !== 1'b1 && t < 20) begin @(negedge clkB); t++; end
    repeat (2) @(negedge clkB);
    bus.async_req_i = 1'b0;
    repeat (8) @(negedge clkB);
    checks++;
    if (protoCnt != 1) begin
      errors++;
      $display("FAIL proto_pulse cycles=%0d required 1", protoCnt);
    end
    checks++;
    if (bus.valid_o !== 1'b1 || bus.data_o !== 8'h5A) begin
      errors++;
      $display("FAIL proto_hold valid=%b data=%h required 1 5a", bus.valid_o, bus.data_o);
    end
    rdyMode = 1;
    t = 0;
    while (bus.ack_o !== 1'b1 && t < 20) begin @(negedge clkB); t++; end
    checks++;
    if (bus.ack_o !== 1'b1) begin
      errors++;
      $display("FAIL proto_ack ack_o=%b required 1", bus.ack_o);
    end
    t = 0;
    while (bus.ack_o !== 1'b0 && t < 20) begin @(negedge clkB); t++; end
    checks++;
    if (accQ.size() != 1 || accQ[0] !== 8'h5A || protoCnt != 1) begin
      errors++;
      $display("FAIL proto_deliver count=%0d perr=%0d required 1 word, 1 pulse", accQ.size(), protoCnt);
    end
  endtask

`ifdef CDC_HS_RX_PARITY_EN
  task automatic test_parity();
    int t;
    for (int k = 0; k < 2; k++) begin
      rdyMode = 0;
      @(negedge clkB);
      bus.async_data_i = 8'h01;
      bus.async_par_i  = (k == 1);
      bus.async_req_i  = 1'b1;
      t = 0;
      while (bus.valid_o !== 1'b1 && t < 20) begin @(negedge clkB); t++; end
      checks++;
      if (bus.valid_o !== 1'b1 || bus.par_err_o !== (k == 0)) begin
        errors++;
        $display("FAIL parity_case%0d valid=%b par_err=%b required 1 %b", k, bus.valid_o, bus.par_err_o, (k == 0));
      end
      rdyMode = 1;
      t = 0;
      while (bus.ack_o !== 1'b1 && t < 20) begin @(negedge clkB); t++; end
      checks++;
      if (bus.par_err_o !== 1'b0) begin
        errors++;
        $display("FAIL parity_clear%0d par_err=%b required 0", k, bus.par_err_o);
      end
      bus.async_req_i = 1'b0;
      t = 0;
      while (bus.ack_o !== 1'b0 && t < 20) begin @(negedge clkB); t++; end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_ready_hold();
    test_back_to_back(15.0, "slowA");
    test_back_to_back(1.7, "fastA");
    test_stale_req();
    test_proto_err();
`ifdef CDC_HS_RX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
